// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: 128-bit block type, FSM state enum,
// inverse S-box table and GF(2^8) arithmetic helpers.
package aes_pkg;

    // Byte 0 occupies bits [0:7]; bit 0 is the MSB of byte 0.
    typedef logic [0:127] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    // Inverse S-box, entry b at bits [8*b +: 8].
    localparam logic [0:2047] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[8*int'(b) +: 8];
    endfunction

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply; with a constant b this collapses to a few XORs.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/decrypt_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last_i).
module decrypt_round
    import aes_pkg::*;
(
    input  block_t state_i,
    input  block_t round_key_i,
    input  logic   last_i,
    output block_t state_o
);

    function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[0:7];
        s1 = col[8:15];
        s2 = col[16:23];
        s3 = col[24:31];
        return {gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
                gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
                gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
                gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)};
    endfunction

    block_t sub_w;
    block_t add_w;
    block_t mix_w;

    // Byte index is 4*column + row; row r rotates right by r columns.
    always_comb begin
        sub_w = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_w[8*(4*c + r) +: 8] = inv_sbox(state_i[8*(4*((c - r + 4) % 4) + r) +: 8]);
            end
        end
        add_w = sub_w ^ round_key_i;
        mix_w = '0;
        for (int c = 0; c < 4; c++) begin
            mix_w[32*c +: 32] = inv_mix_col(add_w[32*c +: 32]);
        end
        state_o = last_i ? add_w : mix_w;
    end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher, one round per clock.
// Optional build macro AES_DEC_KEY_LATCH_EN: latch keySchedule at start accept
// so the caller may change it while the block is in flight.
module aes_decrypt
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [0:127]          cipher,
    input  logic [0:128*(nr+1)-1] keySchedule,
    output logic [0:127]          message,
    output logic                  ready,
    output logic                  done
);

    if (nr != nk + 6) begin : g_bad_cfg
        $error("aes_decrypt: nr must equal nk + 6");
    end

    aes_state_e            fsm_q;
    block_t                state_q;
    block_t                message_q;
    logic [3:0]            rnd_q;
    logic                  done_q;
    logic [0:128*(nr+1)-1] keys_w;
    block_t                rk_w [0:nr];
    block_t                round_key_w;
    block_t                round_out_w;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [0:128*(nr+1)-1] key_q;

    // Capture the full schedule on the accepting edge; rounds use only this copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q <= '0;
        end else if (fsm_q == IDLE && start) begin
            key_q <= keySchedule;
        end
    end

    assign keys_w = key_q;
`else
    assign keys_w = keySchedule;
`endif

    for (genvar r = 0; r <= nr; r++) begin : g_rk
        assign rk_w[r] = keys_w[128*r +: 128];
    end

    // rnd_q reaches 0 exactly when LAST is entered, so it also selects K[0].
    assign round_key_w = rk_w[rnd_q];

    decrypt_round u_round (
        .state_i     (state_q),
        .round_key_i (round_key_w),
        .last_i      (fsm_q == LAST),
        .state_o     (round_out_w)
    );

    // Sequencer: initial key add in IDLE, nr-1 full rounds, final round, done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            rnd_q     <= 4'd0;
            message_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q <= cipher ^ keySchedule[128*nr +: 128];
                        rnd_q   <= 4'(nr - 1);
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    state_q <= round_out_w;
                    rnd_q   <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) fsm_q <= LAST;
                end
                LAST: begin
                    state_q   <= round_out_w;
                    message_q <= round_out_w;
                    done_q    <= 1'b1;
                    fsm_q     <= DONE;
                end
                DONE: begin
                    fsm_q <= IDLE;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign message = message_q;
    assign done    = done_q;
    assign ready   = (fsm_q == IDLE);

endmodule
